// File: rtl/alu_op_pkg.sv
// Shared ALU op-code definitions used by both the op decoder and the op encoder.
// Also carries the encoder's output-buffer occupancy states.
package alu_op_pkg;

  localparam int OP_W      = 4;
  localparam int N_OPS     = 2 ** OP_W;
  localparam int ERR_CNT_W = 8;

  typedef logic [OP_W-1:0] op_t;

  typedef struct packed {
    op_t  op;
    logic err;
  } enc_entry_t;

  localparam op_t OP_ADD  = 4'd0;
  localparam op_t OP_SUB  = 4'd1;
  localparam op_t OP_AND  = 4'd2;
  localparam op_t OP_OR   = 4'd3;
  localparam op_t OP_XOR  = 4'd4;
  localparam op_t OP_NOT  = 4'd5;
  localparam op_t OP_SLL  = 4'd6;
  localparam op_t OP_SRL  = 4'd7;
  localparam op_t OP_SRA  = 4'd8;
  localparam op_t OP_ROL  = 4'd9;
  localparam op_t OP_ROR  = 4'd10;
  localparam op_t OP_MUL  = 4'd11;
  localparam op_t OP_CMP  = 4'd12;
  localparam op_t OP_MIN  = 4'd13;
  localparam op_t OP_MAX  = 4'd14;
  localparam op_t OP_PASS = 4'd15;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/op_prio_enc.sv
// Combinational lowest-bit-first priority encoder with a one-hot check.
// err is raised for an all-zero vector and for any vector with more than one bit set.
module op_prio_enc
  import alu_op_pkg::*;
#(
  parameter int N_OPS = alu_op_pkg::N_OPS,
  parameter int OP_W  = alu_op_pkg::OP_W
) (
  input  logic [N_OPS-1:0] active,
  output logic [OP_W-1:0]  op,
  output logic             err
);

  // below_any[i] is set when any bit strictly below position i is set.
  logic [N_OPS:0]   below_any;
  logic [N_OPS-1:0] first_hit;
  logic [N_OPS-1:0] extra_hit;

  assign below_any[0] = 1'b0;

  for (genvar gi = 0; gi < N_OPS; gi++) begin : g_chain
    assign below_any[gi+1] = below_any[gi] | active[gi];
    assign first_hit[gi]   = active[gi] & ~below_any[gi];
    assign extra_hit[gi]   = active[gi] &  below_any[gi];
  end

  always_comb begin
    op = '0;
    for (int i = 0; i < N_OPS; i++) begin
      if (first_hit[i]) op = OP_W'(i);
    end
  end

  assign err = ~below_any[N_OPS] | (|extra_hit);

endmodule

// File: rtl/op_encoder.sv
// Encodes one-hot unit-done vectors into op codes, buffers them in a 2-entry FIFO
// with valid/ready on both sides, and counts malformed vectors (saturating).
module op_encoder
  import alu_op_pkg::*;
#(
  parameter int N_OPS     = alu_op_pkg::N_OPS,
  parameter int OP_W      = alu_op_pkg::OP_W,
  parameter int ERR_CNT_W = alu_op_pkg::ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_OPS-1:0]     active,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OP_W-1:0]      out_op,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 clr_err
);

  logic [OP_W-1:0]      enc_op;
  logic                 enc_err;
  logic                 push;
  logic                 pop;
  buf_state_t           state_q, state_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [OP_W-1:0]      entry_op  [2];
  logic                 entry_err [2];

  op_prio_enc #(
    .N_OPS (N_OPS),
    .OP_W  (OP_W)
  ) u_prio_enc (
    .active (active),
    .op     (enc_op),
    .err    (enc_err)
  );

  // Handshake depends only on registered occupancy, so out_ready never reaches in_ready.
  assign in_ready  = (state_q != BUF_FULL);
  assign out_valid = (state_q != BUF_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_op    = entry_op[rd_ptr_q];
  assign out_err   = entry_err[rd_ptr_q];

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    logic [OP_W-1:0] op_q, op_d;
    logic            err_q, err_d;

    always_comb begin
      op_d  = op_q;
      err_d = err_q;
      if (push && (wr_ptr_q == 1'(gi))) begin
        op_d  = enc_op;
        err_d = enc_err;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        op_q  <= '0;
        err_q <= 1'b0;
      end else begin
        op_q  <= op_d;
        err_q <= err_d;
      end
    end

    assign entry_op[gi]  = op_q;
    assign entry_err[gi] = err_q;
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop;
    err_cnt_d = err_cnt_q;

    case (state_q)
      BUF_EMPTY: if (push) state_d = BUF_ONE;
      BUF_ONE: begin
        if (push && !pop)      state_d = BUF_FULL;
        else if (pop && !push) state_d = BUF_EMPTY;
      end
      BUF_FULL:  if (pop) state_d = BUF_ONE;
      default:   state_d = BUF_EMPTY;
    endcase

    if (clr_err) begin
      err_cnt_d = '0;
    end else if (push && enc_err && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BUF_EMPTY;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_op_encoder.sv
// Directed bench for op_encoder: a vector table for single accepts plus
// hand-written sequences for back-pressure, push/pop overlap, saturation and reset.
module tb_op_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] active;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic        out_err;
  logic [7:0]  err_count;
  logic        clr_err;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] active;
    logic [3:0]  op;
    logic        err;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs [8];

  op_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .active    (active),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_err   (out_err),
    .err_count (err_count),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h (t=%0t)", name, act, $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{16'h0001, 4'd0,  1'b0, 8'd0};
    vecs[1] = '{16'h0080, 4'd7,  1'b0, 8'd0};
    vecs[2] = '{16'h8000, 4'd15, 1'b0, 8'd0};
    vecs[3] = '{16'h0000, 4'd0,  1'b1, 8'd1};
    vecs[4] = '{16'h0006, 4'd1,  1'b1, 8'd2};
    vecs[5] = '{16'h0400, 4'd10, 1'b0, 8'd2};
    vecs[6] = '{16'hFFFF, 4'd0,  1'b1, 8'd3};
    vecs[7] = '{16'h8080, 4'd7,  1'b1, 8'd4};

    in_valid  = 1'b0;
    active    = '0;
    out_ready = 1'b1;
    clr_err   = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #1;
    chk("rst in_ready",  32'(in_ready),  32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_op",    32'(out_op),    32'd0);
    chk("rst out_err",   32'(out_err),   32'd0);
    chk("rst err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: one accept, visible one cycle later, then drained.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      active   = vecs[i].active;
      @(negedge clk);
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d out_op", i),    32'(out_op),    32'(vecs[i].op));
      chk($sformatf("vec%0d out_err", i),   32'(out_err),   32'(vecs[i].err));
      chk($sformatf("vec%0d err_count", i), 32'(err_count), 32'(vecs[i].cnt));
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d drained", i),   32'(out_valid), 32'd0);
    end

    // Back-pressure: fill the buffer, third vector must be refused.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    active    = 16'h0004;
    @(negedge clk);
    chk("bp in_ready one",  32'(in_ready), 32'd1);
    chk("bp head one",      32'(out_op),   32'd2);
    active = 16'h0010;
    @(negedge clk);
    chk("bp in_ready full", 32'(in_ready), 32'd0);
    chk("bp head full",     32'(out_op),   32'd2);
    active = 16'h0001;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp still full",    32'(in_ready), 32'd0);
    chk("bp head kept",     32'(out_op),   32'd2);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp second op",     32'(out_op),   32'd4);
    chk("bp in_ready back", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("bp third refused", 32'(out_valid), 32'd0);
    chk("bp err_count",     32'(err_count), 32'd4);

    // Simultaneous push and pop with one entry held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    active    = 16'h0020;
    @(negedge clk);
    chk("pp head first",  32'(out_op), 32'd5);
    active    = 16'h0200;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("pp out_valid",   32'(out_valid), 32'd1);
    chk("pp new head",    32'(out_op),    32'd9);
    chk("pp in_ready",    32'(in_ready),  32'd1);
    @(negedge clk);
    chk("pp head stable", 32'(out_op),    32'd9);
    out_ready = 1'b1;
    @(negedge clk);
    chk("pp only one",    32'(out_valid), 32'd0);

    // Counter clear, saturation, and clear winning over an erroneous accept.
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("clr alone", 32'(err_count), 32'd0);
    in_valid = 1'b1;
    active   = 16'h0003;
    repeat (254) @(negedge clk);
    chk("sat 254", 32'(err_count), 32'd254);
    @(negedge clk);
    chk("sat 255", 32'(err_count), 32'd255);
    @(negedge clk);
    chk("sat hold", 32'(err_count), 32'd255);
    chk("sat head op",  32'(out_op),  32'd0);
    chk("sat head err", 32'(out_err), 32'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err  = 1'b0;
    in_valid = 1'b0;
    chk("clr wins", 32'(err_count), 32'd0);
    @(negedge clk);
    chk("sat drained", 32'(out_valid), 32'd0);

    // Asynchronous reset while FULL.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    active    = 16'h0000;
    @(negedge clk);
    active    = 16'h0040;
    @(negedge clk);
    in_valid  = 1'b0;
    chk("pre-rst full", 32'(in_ready),  32'd0);
    chk("pre-rst errs", 32'(err_count), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-rst out_valid", 32'(out_valid), 32'd0);
    chk("mid-rst in_ready",  32'(in_ready),  32'd1);
    chk("mid-rst err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    active   = 16'h0100;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post-rst valid", 32'(out_valid), 32'd1);
    chk("post-rst op",    32'(out_op),    32'd8);
    chk("post-rst err",   32'(out_err),   32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("post-rst alone", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/op_encoder.md
Name: op_encoder

Overview:
- Reverse direction of the ALU operation decoder: takes a 16-bit one-hot "active" vector and returns the 4-bit op code.
- Sits on the ALU result/status return path. Each functional unit raises its one-hot line when done; this block encodes the line, flags malformed vectors and buffers results for the sequencer.
- Uses a valid/ready handshake on both sides with a 2-entry output buffer.

Parameters:
- N_OPS, 16, number of one-hot lines (must equal 2**OP_W)
- OP_W, 4, op code width
- ERR_CNT_W, 8, width of saturating error counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  active vector presented
- in_ready  output  1  block can accept a vector this cycle
- active  input  N_OPS  one-hot unit-done vector
- out_valid  output  1  encoded entry available at head
- out_ready  input  1  consumer takes head entry this cycle
- out_op  output  OP_W  encoded op code of head entry
- out_err  output  1  head entry came from a non-one-hot vector
- err_count  output  ERR_CNT_W  saturating count of malformed vectors accepted
- clr_err  input  1  synchronous clear of err_count

Behaviour:
- One clock; rst_n asynchronous, active-low; all state resets on assertion, independent of clk.
- Reset values:
  - in_ready=1, out_valid=0, out_op=0, out_err=0, err_count=0.
  - Buffer count=0; read and write pointers=0.
- Encoding (combinational, on accept):
  - out_op = index of the lowest set bit of active (priority to bit 0).
  - err = 1 if popcount(active) != 1.
  - active == 0 encodes op=0 with err=1.
  - Multi-hot, e.g. 0x0006, encodes op=1 with err=1.
- Accept: push occurs when in_valid && in_ready.
- Pop: occurs when out_valid && out_ready.
- Buffer: 2-entry FIFO of {op, err}; states EMPTY (count 0), ONE (1), FULL (2).
  - in_ready = (count != 2). It is registered-state derived and does not depend on out_ready, so there is no combinational path from out_ready to in_ready.
  - out_valid = (count != 0). out_op and out_err are driven from the head entry register.
- Latency: a vector accepted at edge N makes out_valid high after edge N, and it is visible in cycle N+1.
- Transitions:
  - EMPTY: push -> ONE.
  - ONE: push without pop -> FULL; pop without push -> EMPTY; push and pop together -> ONE, with the new entry at the head next cycle.
  - FULL: pop -> ONE. in_valid is ignored while FULL.
- Ordering: strict FIFO. Pointers are 1 bit and wrap 1->0.
- err_count:
  - Increments on each accepted vector with err=1.
  - Saturates at 2**ERR_CNT_W-1.
  - If clr_err is asserted in the same cycle as an erroneous accept, clear wins and err_count becomes 0.
- Reset mid-operation: buffered entries are discarded, out_valid drops immediately (asynchronously) and in_ready returns to 1.
- active is sampled only on accept; values at other times are don't-care.

Decomposition:
- Shared package alu_op_pkg:
  - Constants OP_W, N_OPS.
  - typedef op_t (logic [OP_W-1:0]).
  - typedef struct enc_entry_t {op_t op; logic err;}.
  - Named op code constants shared with the decoder.
- Sub-module op_prio_enc: purely combinational; input active, outputs op and err (lowest-bit priority plus popcount check).
- op_encoder holds the FIFO, handshake and counter.

Test Plan:
- Reset, then send active=0x0001, 0x0080, 0x8000 with out_ready=1 -> out_op 0, 7, 15 each one cycle after accept; out_err=0; err_count=0.
- Send active=0x0000 -> out_op=0, out_err=1, err_count=1. Then send active=0x0006 -> out_op=1, out_err=1, err_count=2.
- Hold out_ready=0 and push 0x0004, 0x0010 -> in_ready=0 after the second accept and a third in_valid is not accepted. Then raise out_ready -> ops 2 then 4 in order, and in_ready returns to 1.
- Count=1, simultaneous push 0x0200 and pop -> count stays 1; next head out_op=9.
- Push 255 malformed vectors, then one more -> err_count stays 255. Assert clr_err together with an erroneous accept -> err_count=0.
- Buffer FULL, assert rst_n=0 mid-cycle -> out_valid=0 and in_ready=1 immediately, err_count=0. The first push after reset appears alone at the output.
